// File: rtl/pmp_pkg.sv
// Shared types and encodings for the physical memory protection check.
package pmp_pkg;

  localparam int pmp_msb_dflt = 55;
  localparam int pmpaddrbits  = pmp_msb_dflt - 1;

  typedef logic [63:0]              word64;
  typedef logic [pmpaddrbits-1:0]   pmpaddr_type;
  typedef pmpaddr_type [15:0]       pmpaddr_vec_type;

  localparam logic [1:0] a_off   = 2'b00;
  localparam logic [1:0] a_tor   = 2'b01;
  localparam logic [1:0] a_na4   = 2'b10;
  localparam logic [1:0] a_napot = 2'b11;

  localparam logic [1:0] acc_x = 2'b00;
  localparam logic [1:0] acc_r = 2'b01;
  localparam logic [1:0] acc_w = 2'b11;

  localparam logic [1:0] prv_m = 2'b11;

  // Config byte idx of the combined pmpcfg0 (entries 0-7) / pmpcfg2 (entries 8-15) pair.
  function automatic logic [7:0] cfg_byte(input word64 cfg0, input word64 cfg2,
                                          input logic [3:0] idx);
    logic [127:0] all_cfg;
    all_cfg = {cfg2, cfg0};
    return all_cfg[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pmp_match.sv
// One PMP entry: turns the entry's address mode into an inclusive byte region and
// reports whether the access range lies fully inside it or merely touches it.
module pmp_match
  import pmp_pkg::*;
#(
  parameter int pmp_no_tor = 0,
  parameter int pmp_g      = 10,
  parameter int pmp_msb    = 55
) (
  input  logic [pmp_msb-2:0] pa,
  input  logic [pmp_msb-2:0] pa_prev,
  input  logic [1:0]         a_mode,
  input  logic [pmp_msb+1:0] lo,
  input  logic [pmp_msb+1:0] hi,
  output logic               full,
  output logic               any
);

  localparam int paw = pmp_msb - 1;
  localparam int bw  = pmp_msb + 2;
  localparam logic [paw-1:0] g_clr = ~((paw'(1) << pmp_g) - paw'(1));
  localparam logic [paw-1:0] g_set =
    (pmp_g >= 2) ? ((paw'(1) << ((pmp_g >= 2) ? pmp_g - 1 : 0)) - paw'(1)) : '0;

  logic [paw-1:0] pa_eff;
  logic [paw-1:0] low_ones;
  logic [bw-1:0]  tor_top;
  logic [bw-1:0]  rbase;
  logic [bw-1:0]  rlast;
  logic           rvalid;
  logic           unused_in;

  assign unused_in = ^pa_prev;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    pa_eff   = pa | g_set;
    // NAPOT: bits [t:0] set, where t is the trailing-ones count of the entry.
    low_ones = pa_eff ^ (pa_eff + paw'(1));
    tor_top  = {1'b0, pa & g_clr, 2'b00};
    rbase    = '0;
    rlast    = '0;
    rvalid   = 1'b0;
    case (a_mode)
      a_off: begin
      end
      a_tor: begin
        if (pmp_no_tor == 0) begin
          rbase  = {1'b0, pa_prev & g_clr, 2'b00};
          rlast  = tor_top - bw'(1);
          rvalid = rbase < tor_top;
        end
      end
      a_na4: begin
        if (pmp_g == 0) begin
          rbase  = {1'b0, pa, 2'b00};
          rlast  = {1'b0, pa, 2'b11};
          rvalid = 1'b1;
        end
      end
      default: begin
        rbase  = {1'b0, pa_eff & ~low_ones, 2'b00};
        rlast  = {1'b0, pa_eff | low_ones, 2'b11};
        rvalid = 1'b1;
      end
    endcase
  end

  assign full = rvalid && (lo >= rbase) && (hi <= rlast);
  assign any  = rvalid && (lo <= rlast) && (hi >= rbase);

endmodule

// File: rtl/end_function.sv
// PMP access check: per-entry matchers, lowest-index priority select and a
// registered grant one cycle after the inputs are sampled.
module end_function
  import pmp_pkg::*;
#(
  parameter int pmp_check   = 1,
  parameter int pmp_no_tor  = 0,
  parameter int pmp_entries = 16,
  parameter int pmp_g       = 10,
  parameter int pmp_msb     = 55
) (
  input  logic                                clk300p,
  input  logic                                rstn,
  input  logic [pmp_entries-1:0][pmp_msb-2:0] pmpaddr,
  input  word64                               pmpcfg0,
  input  word64                               pmpcfg2,
  input  logic [pmp_msb:0]                    address,
  input  logic [1:0]                          acc,
  input  logic [1:0]                          size,
  input  logic [1:0]                          prv,
  input  logic                                mprv,
  input  logic [1:0]                          mpp,
  input  logic                                valid,
  output logic                                ok
);

  localparam int bw = pmp_msb + 2;

  logic [bw-1:0]                lo;
  logic [bw-1:0]                hi;
  logic [pmp_entries-1:0]       m_full;
  logic [pmp_entries-1:0]       m_any;
  logic [pmp_entries-1:0][7:0]  cfg;
  logic                         hit;
  logic                         hit_full;
  logic [7:0]                   hit_cfg;
  logic [1:0]                   eff_prv;
  logic                         is_m;
  logic                         perm;
  logic                         grant;
  logic                         unused_ok;

  // Extra top bit keeps the carry so a range crossing the top of memory cannot wrap.
  assign lo = {1'b0, address};
  assign hi = lo + (bw'(1) << size) - bw'(1);

  for (genvar i = 0; i < pmp_entries; i++) begin : g_entry
    logic [pmp_msb-2:0] pa_prev;
    assign cfg[i] = cfg_byte(pmpcfg0, pmpcfg2, 4'(i));
    if (i == 0) begin : g_first
      assign pa_prev = '0;
    end else begin : g_rest
      assign pa_prev = pmpaddr[i-1];
    end
    pmp_match #(
      .pmp_no_tor (pmp_no_tor),
      .pmp_g      (pmp_g),
      .pmp_msb    (pmp_msb)
    ) u_match (
      .pa      (pmpaddr[i]),
      .pa_prev (pa_prev),
      .a_mode  (cfg[i][4:3]),
      .lo      (lo),
      .hi      (hi),
      .full    (m_full[i]),
      .any     (m_any[i])
    );
  end

  assign unused_ok = ^{valid, cfg};

  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_cfg  = '0;
    // Scan downward so the lowest matching index is the last one written.
    for (int i = pmp_entries - 1; i >= 0; i--) begin
      if (m_any[i]) begin
        hit      = 1'b1;
        hit_full = m_full[i];
        hit_cfg  = cfg[i];
      end
    end
    eff_prv = (mprv && (acc != acc_x)) ? mpp : prv;
    is_m    = (eff_prv == prv_m);
    case (acc)
      acc_x:   perm = hit_cfg[2];
      acc_r:   perm = hit_cfg[0];
      acc_w:   perm = hit_cfg[1];
      default: perm = 1'b0;
    endcase
    if (!hit)                    grant = is_m;
    else if (!hit_full)          grant = 1'b0;
    else if (!hit_cfg[7] && is_m) grant = 1'b1;
    else                         grant = perm;
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk300p) begin
    if (rstn)                ok <= 1'b0;
    else if (pmp_check == 0) ok <= 1'b1;
    else                     ok <= grant;
  end

endmodule

// File: tb/tb_end_function.sv
// Self-checking bench for end_function: directed scenarios plus randomized
// configurations compared against an interval-arithmetic reference model.
module tb_end_function;

  localparam int G = 10;

  logic                 clk300p = 1'b0;
  logic                 rstn;
  logic [15:0][53:0]    pmpaddr;
  logic [63:0]          pmpcfg0;
  logic [63:0]          pmpcfg2;
  logic [55:0]          address;
  logic [1:0]           acc;
  logic [1:0]           size;
  logic [1:0]           prv;
  logic                 mprv;
  logic [1:0]           mpp;
  logic                 valid;
  logic                 ok;

  int checks = 0;
  int errors = 0;

  always #5 clk300p = ~clk300p;

  end_function dut (
    .clk300p (clk300p),
    .rstn    (rstn),
    .pmpaddr (pmpaddr),
    .pmpcfg0 (pmpcfg0),
    .pmpcfg2 (pmpcfg2),
    .address (address),
    .acc     (acc),
    .size    (size),
    .prv     (prv),
    .mprv    (mprv),
    .mpp     (mpp),
    .valid   (valid),
    .ok      (ok)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: ok=%0b expected %0b (addr=%0h acc=%0b size=%0d prv=%0b mprv=%0b mpp=%0b)",
               tag, got, exp, address, acc, size, prv, mprv, mpp);
    end
  endtask

  // Reference: each entry as a half-open byte interval [b, e) in plain 64-bit arithmetic.
  function automatic bit model_ok();
    longint unsigned lo, hi, b, e, p, rsz;
    logic [127:0]    cfgs;
    logic [7:0]      c;
    logic [1:0]      eff;
    bit              m_eff, perm;
    int              t;
    cfgs  = {pmpcfg2, pmpcfg0};
    eff   = (mprv && acc != 2'b00) ? mpp : prv;
    m_eff = (eff == 2'b11);
    lo    = 64'(address);
    hi    = lo + (64'd1 << size) - 64'd1;
    for (int i = 0; i < 16; i++) begin
      c = cfgs[i*8 +: 8];
      b = 0;
      e = 0;
      if (c[4:3] == 2'b01) begin
        if (i == 0) b = 0;
        else        b = ((64'(pmpaddr[i-1]) >> G) << G) << 2;
        e = ((64'(pmpaddr[i]) >> G) << G) << 2;
      end else if (c[4:3] == 2'b10) begin
        if (G == 0) begin
          b = 64'(pmpaddr[i]) << 2;
          e = b + 4;
        end
      end else if (c[4:3] == 2'b11) begin
        p = 64'(pmpaddr[i]) | ((64'd1 << (G - 1)) - 64'd1);
        t = 0;
        while (t < 54 && p[t]) t++;
        rsz = 64'd1 << (t + 3);
        b   = (p << 2) & ~(rsz - 64'd1);
        e   = b + rsz;
      end
      if (b >= e) continue;
      if (hi < b || lo >= e) continue;
      if (!(lo >= b && hi < e)) return 1'b0;
      if (!c[7] && m_eff) return 1'b1;
      case (acc)
        2'b00:   perm = c[2];
        2'b01:   perm = c[0];
        2'b11:   perm = c[1];
        default: perm = 1'b0;
      endcase
      return perm;
    end
    return m_eff;
  endfunction

  task automatic drive(input logic [55:0] a, input logic [1:0] ac, input logic [1:0] sz,
                       input logic [1:0] pv, input logic mp, input logic [1:0] mpp_i);
    address = a;
    acc     = ac;
    size    = sz;
    prv     = pv;
    mprv    = mp;
    mpp     = mpp_i;
  endtask

  task automatic step(input string tag, input logic exp);
    @(posedge clk300p);
    #1;
    check(tag, ok, exp);
  endtask

  task automatic clear_cfg();
    pmpaddr = '0;
    pmpcfg0 = '0;
    pmpcfg2 = '0;
  endtask

  initial begin
    logic [1:0]  acc_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0]  prv_tab [3] = '{2'b00, 2'b01, 2'b11};
    logic        exp;
    rstn  = 1'b1;
    valid = 1'b1;
    clear_cfg();
    pmpaddr[0] = 54'h1FF;
    pmpcfg0    = 64'h1B;
    drive(56'h100, 2'b01, 2'd3, 2'b11, 1'b0, 2'b00);
    step("reset_hold0", 1'b0);
    step("reset_hold1", 1'b0);
    rstn = 1'b0;
    step("first_after_reset", 1'b1);

    // 4 KiB NAPOT region at 0, RW only
    drive(56'h100, 2'b01, 2'd3, 2'b00, 1'b0, 2'b00);
    step("napot_u_read", 1'b1);
    acc = 2'b00;
    step("napot_u_fetch", 1'b0);
    drive(56'h2000, 2'b01, 2'd3, 2'b00, 1'b0, 2'b00);
    step("nomatch_u", 1'b0);
    prv = 2'b11;
    step("nomatch_m", 1'b1);

    // Locked W-only region binds M-mode too
    pmpcfg0 = 64'h9A;
    drive(56'h100, 2'b01, 2'd3, 2'b11, 1'b0, 2'b00);
    step("locked_m_read", 1'b0);
    acc = 2'b11;
    step("locked_m_write", 1'b1);

    // TOR [0x1000, 0x2000), read only
    clear_cfg();
    pmpaddr[0] = 54'h400;
    pmpaddr[1] = 54'h800;
    pmpcfg0    = 64'h0900;
    drive(56'h1000, 2'b01, 2'd3, 2'b01, 1'b0, 2'b00);
    step("tor_s_read", 1'b1);
    address = 56'h1FFC;
    step("tor_s_partial", 1'b0);
    prv = 2'b11;
    step("tor_m_partial", 1'b0);

    // MPRV redirects loads/stores but not fetches
    clear_cfg();
    pmpaddr[0] = 54'h1FF;
    pmpcfg0    = 64'h1B;
    drive(56'h2000, 2'b11, 2'd3, 2'b11, 1'b1, 2'b00);
    step("mprv_write", 1'b0);
    acc = 2'b00;
    step("mprv_fetch", 1'b1);

    // Access straddling the top of memory must not wrap into the region
    clear_cfg();
    pmpaddr[0] = (54'd1 << 53) | ((54'd1 << 52) - 54'd1);
    pmpcfg0    = 64'h1B;
    drive(56'hFF_FFFF_FFFF_FFFC, 2'b01, 2'd3, 2'b00, 1'b0, 2'b00);
    step("top_carry", 1'b0);
    address = 56'hFF_FFFF_FFFF_FFF8;
    step("top_inside", 1'b1);

    // Reset mid-operation discards the pending grant
    prv  = 2'b11;
    rstn = 1'b1;
    step("reset_mid", 1'b0);
    rstn = 1'b0;
    step("reset_release", 1'b1);

    for (int n = 0; n < 600; n++) begin
      if (n % 16 == 0) begin
        for (int i = 0; i < 16; i++) begin
          pmpaddr[i] = 54'(($urandom_range(0, 20) << 10) | ((1 << $urandom_range(0, 13)) - 1));
          if (i < 8) pmpcfg0[i*8 +: 8]     = 8'($urandom) & 8'h9F;
          else       pmpcfg2[(i-8)*8 +: 8] = 8'($urandom) & 8'h9F;
        end
      end
      if ($urandom_range(0, 7) == 0)
        address = 56'hFF_FFFF_FFFF_FFFF - 56'($urandom_range(0, 16));
      else
        address = 56'($urandom_range(0, 'h16000));
      acc  = acc_tab[$urandom_range(0, 3)];
      size = 2'($urandom_range(0, 3));
      prv  = prv_tab[$urandom_range(0, 2)];
      mprv = 1'($urandom);
      mpp  = prv_tab[$urandom_range(0, 2)];
      if ($urandom_range(0, 31) == 0) begin
        rstn = 1'b1;
        exp  = 1'b0;
      end else begin
        rstn = 1'b0;
        exp  = model_ok();
      end
      step("random", exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/end_function.md
END_FUNCTION -- requirements
Module: end_function

Interface
REQ-001 Parameters: pmp_check (default 1; 0 disables checking), pmp_no_tor (default 0; nonzero disables TOR), pmp_entries (default 16, max 16), pmp_g (default 10, granularity G), pmp_msb (default 55, physical address MSB).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk300p  in  1  clock; all state on rising edge.
REQ-004 rstn  in  1  synchronous active-high reset (asserted = 1); keeps the codebase port name.
REQ-005 pmpaddr  in  pmp_entries x (pmp_msb-1)  pmpaddr CSRs; each entry holds address bits [pmp_msb:2].
REQ-006 pmpcfg0  in  64  config bytes for entries 0-7; byte i: bit0 R, bit1 W, bit2 X, bits4:3 A, bit7 L.
REQ-007 pmpcfg2  in  64  config bytes for entries 8-15, same layout.
REQ-008 address  in  pmp_msb+1  physical byte address of the access.
REQ-009 acc  in  2  access type: 00 fetch (X), 01 read (R), 11 write (W).
REQ-010 size  in  2  access size, 2^size bytes.
REQ-011 prv  in  2  current privilege: 00 U, 01 S, 11 M.
REQ-012 mprv, mpp  in  1, 2  mstatus.MPRV and mstatus.MPP.
REQ-013 valid  in  1  access qualifier; does not gate the check.
REQ-014 ok  out  1  registered grant, 1 = access permitted.

Function
REQ-015 ok SHALL be the check result of the inputs sampled at the previous rising edge (latency 1); evaluated every cycle regardless of valid.
REQ-016 Effective privilege SHALL be mpp when mprv=1 and acc!=X, else prv.
REQ-017 Access byte range SHALL be [address, address+2^size-1], computed with carry (no wrap).
REQ-018 A-field modes: 00 OFF (never matches), 01 TOR, 10 NA4, 11 NAPOT.
REQ-019 TOR entry i SHALL match bytes in [pmpaddr[i-1]<<2, pmpaddr[i]<<2); entry 0 uses lower bound 0; low G bits of both bounds read as 0.
REQ-020 NA4 SHALL match the 4-byte word pmpaddr[i]<<2; when pmp_g>0, NA4 SHALL be treated as OFF.
REQ-021 NAPOT: trailing ones count t of pmpaddr[i] SHALL define region size 2^(t+3) bytes; when pmp_g>=2, low G-1 bits read as 1.
REQ-022 pmp_no_tor!=0: TOR SHALL be treated as OFF.
REQ-023 Entries SHALL be priority-checked lowest index first; first entry matching any byte decides.
REQ-024 Decisive entry matching only part of the range SHALL deny, in all privilege modes.
REQ-025 Full match: grant if L=0 and effective privilege M; otherwise grant iff permission bit for acc (R/W/X) is 1.
REQ-026 No match: grant iff effective privilege is M.
REQ-027 Misaligned accesses SHALL be checked by range like any other.
REQ-028 pmp_check=0: ok SHALL be 1 every cycle after reset.
REQ-029 Entries >= pmp_entries SHALL be treated as OFF.

Reset
REQ-030 While rstn=1 at a rising edge, ok SHALL become 0; first real result appears one cycle after deassertion.
REQ-031 No other state; reset mid-operation discards the pending result.

Structure
REQ-032 Package pmp_pkg SHALL hold word64, pmpaddr_type, pmpaddr_vec_type, pmpaddrbits (= pmp_msb-1) and A-mode/access-type constants.
REQ-033 One sub-module pmp_match (per-entry full/partial match for TOR/NA4/NAPOT) SHALL be instantiated pmp_entries times; priority encoder and permission logic in end_function.

Verification (G=10, NAPOT pmpaddr0=0x1FF = 4 KiB at 0, other entries OFF)
REQ-034 cfg byte0=0x1B, prv=U, acc=R, address=0x100, size=3 -> ok=1 next cycle; acc=X -> ok=0.
REQ-035 Same setup, address=0x2000: prv=U -> ok=0; prv=M, mprv=0 -> ok=1.
REQ-036 cfg byte0=0x9A (L=1, W only), prv=M, acc=R, address=0x100 -> ok=0; acc=W -> ok=1.
REQ-037 TOR: pmpaddr0=0x400 OFF, pmpaddr1=0x800, cfg byte1=0x09; prv=S read 0x1000 size 3 -> ok=1; 0x1FFC size 3 -> ok=0; prv=M 0x1FFC size 3 -> ok=0.
REQ-038 prv=M, mprv=1, mpp=U, address=0x2000: acc=W -> ok=0; acc=X -> ok=1.
REQ-039 rstn=1 during any above -> ok=0 next cycle.
